// File: rtl/bp_fe_bp_update_fifo.sv
// In-order FIFO of {bht index, prediction} captured at fetch; on resolve it issues
// the table write (valid, index, correct) one cycle later and tracks mispredicts.
module bp_fe_bp_update_fifo #(
    parameter int bht_idx_width_p     = 1,  // must be overridden
    parameter int fifo_els_p          = 8,
    parameter int mispred_cnt_width_p = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic                            enq_v_i,
    input  logic [bht_idx_width_p-1:0]      enq_idx_i,
    input  logic                            enq_pred_i,
    output logic                            enq_ready_o,

    input  logic                            resolve_v_i,
    input  logic                            resolve_taken_i,
    output logic                            resolve_ready_o,

    input  logic                            flush_i,

    output logic                            w_v_o,
    output logic [bht_idx_width_p-1:0]      idx_w_o,
    output logic                            correct_o,

    output logic [$clog2(fifo_els_p):0]     count_o,
    output logic                            underflow_o,
    output logic [mispred_cnt_width_p-1:0]  mispred_cnt_o
);

    localparam int ptr_width_lp   = $clog2(fifo_els_p);
    localparam int cnt_width_lp   = ptr_width_lp + 1;
    localparam int entry_width_lp = bht_idx_width_p + 1;

    // Entry layout: {idx, pred}
    logic [entry_width_lp-1:0]       mem_q [fifo_els_p];

    logic [ptr_width_lp-1:0]         rptr_q, rptr_d;
    logic [ptr_width_lp-1:0]         wptr_q, wptr_d;
    logic [cnt_width_lp-1:0]         count_q, count_d;

    logic                            w_v_q, w_v_d;
    logic [bht_idx_width_p-1:0]      idx_w_q, idx_w_d;
    logic                            correct_q, correct_d;
    logic                            underflow_q, underflow_d;
    logic [mispred_cnt_width_p-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic                            full, empty;
    logic                            enq_fire, res_fire;
    logic [entry_width_lp-1:0]       head_entry;
    logic [bht_idx_width_p-1:0]      head_idx;
    logic                            head_pred;
    logic                            resolve_correct;

    assign full  = (count_q == cnt_width_lp'(fifo_els_p));
    assign empty = (count_q == '0);

    assign enq_ready_o     = ~full;
    assign resolve_ready_o = ~empty;

    // Flush kills both handshakes; readies themselves stay purely state-derived.
    assign enq_fire = enq_v_i & ~full & ~flush_i;
    assign res_fire = resolve_v_i & ~empty & ~flush_i;

    assign head_entry      = mem_q[rptr_q];
    assign head_idx        = head_entry[entry_width_lp-1:1];
    assign head_pred       = head_entry[0];
    assign resolve_correct = (head_pred == resolve_taken_i);

    always_comb begin
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        count_d       = count_q;
        w_v_d         = res_fire;
        idx_w_d       = idx_w_q;
        correct_d     = correct_q;
        underflow_d   = resolve_v_i & empty & ~flush_i;
        mispred_cnt_d = mispred_cnt_q;

        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                wptr_d = wptr_q + ptr_width_lp'(1);
            end
            if (res_fire) begin
                rptr_d = rptr_q + ptr_width_lp'(1);
            end
            if (enq_fire && !res_fire) begin
                count_d = count_q + cnt_width_lp'(1);
            end else if (!enq_fire && res_fire) begin
                count_d = count_q - cnt_width_lp'(1);
            end
        end

        if (res_fire) begin
            idx_w_d   = head_idx;
            correct_d = resolve_correct;
            if (!resolve_correct && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + mispred_cnt_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            w_v_q         <= 1'b0;
            idx_w_q       <= '0;
            correct_q     <= 1'b0;
            underflow_q   <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            w_v_q         <= w_v_d;
            idx_w_q       <= idx_w_d;
            correct_q     <= correct_d;
            underflow_q   <= underflow_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem_q[wptr_q] <= {enq_idx_i, enq_pred_i};
        end
    end

    assign w_v_o         = w_v_q;
    assign idx_w_o       = idx_w_q;
    assign correct_o     = correct_q;
    assign count_o       = count_q;
    assign underflow_o   = underflow_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_bp_fe_bp_update_fifo.sv
// Directed plus random stimulus against a queue-based reference of the update FIFO.
module tb_bp_fe_bp_update_fifo;

    localparam int IW = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enq_v = 1'b0;
    logic [IW-1:0] enq_idx = '0;
    logic          enq_pred = 1'b0;
    logic          res_v = 1'b0;
    logic          res_taken = 1'b0;
    logic          flush = 1'b0;

    logic          enq_ready, res_ready, w_v, correct, underflow;
    logic [IW-1:0] idx_w;
    logic [3:0]    count;
    logic [15:0]   mis16;

    logic          enq_ready2, res_ready2, w_v2, correct2, underflow2;
    logic [IW-1:0] idx_w2;
    logic [3:0]    count2;
    logic [1:0]    mis2;

    bp_fe_bp_update_fifo #(.bht_idx_width_p(IW), .fifo_els_p(DEPTH), .mispred_cnt_width_p(16)) dut (
        .clk_i(clk), .reset_i(rst),
        .enq_v_i(enq_v), .enq_idx_i(enq_idx), .enq_pred_i(enq_pred), .enq_ready_o(enq_ready),
        .resolve_v_i(res_v), .resolve_taken_i(res_taken), .resolve_ready_o(res_ready),
        .flush_i(flush),
        .w_v_o(w_v), .idx_w_o(idx_w), .correct_o(correct),
        .count_o(count), .underflow_o(underflow), .mispred_cnt_o(mis16)
    );

    bp_fe_bp_update_fifo #(.bht_idx_width_p(IW), .fifo_els_p(DEPTH), .mispred_cnt_width_p(2)) dut2 (
        .clk_i(clk), .reset_i(rst),
        .enq_v_i(enq_v), .enq_idx_i(enq_idx), .enq_pred_i(enq_pred), .enq_ready_o(enq_ready2),
        .resolve_v_i(res_v), .resolve_taken_i(res_taken), .resolve_ready_o(res_ready2),
        .flush_i(flush),
        .w_v_o(w_v2), .idx_w_o(idx_w2), .correct_o(correct2),
        .count_o(count2), .underflow_o(underflow2), .mispred_cnt_o(mis2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          pred;
    } entry_t;

    entry_t  q[$];
    int      m_mis = 0;
    logic    m_wv = 1'b0;
    logic [IW-1:0] m_idx = '0;
    logic    m_cor = 1'b0;
    logic    m_uf = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mis = 0;
        m_wv  = 1'b0;
        m_idx = '0;
        m_cor = 1'b0;
        m_uf  = 1'b0;
    endtask

    task automatic chk_all();
        int sat16, sat2;
        sat16 = (m_mis > 65535) ? 65535 : m_mis;
        sat2  = (m_mis > 3) ? 3 : m_mis;
        chk("count", 32'(count), 32'(q.size()));
        chk("enq_ready", 32'(enq_ready), 32'(q.size() < DEPTH));
        chk("resolve_ready", 32'(res_ready), 32'(q.size() > 0));
        chk("w_v", 32'(w_v), 32'(m_wv));
        chk("idx_w", 32'(idx_w), 32'(m_idx));
        chk("correct", 32'(correct), 32'(m_cor));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("mispred16", 32'(mis16), 32'(sat16));
        chk("mispred2", 32'(mis2), 32'(sat2));
        chk("w_v_dut2", 32'(w_v2), 32'(m_wv));
    endtask

    // One clock: drive at negedge, advance model, check 1 time unit after posedge.
    task automatic cycle(input logic ev, input logic [IW-1:0] ei, input logic ep,
                         input logic rv, input logic rt, input logic fl);
        int pre;
        logic acc_enq, acc_res;
        entry_t h;
        @(negedge clk);
        enq_v = ev; enq_idx = ei; enq_pred = ep;
        res_v = rv; res_taken = rt; flush = fl;
        pre = q.size();
        acc_enq = ev && !fl && (pre < DEPTH);
        acc_res = rv && !fl && (pre > 0);
        m_uf = rv && !fl && (pre == 0);
        m_wv = acc_res;
        if (acc_res) begin
            h = q.pop_front();
            m_idx = h.idx;
            m_cor = (h.pred == rt);
            if (!m_cor) m_mis++;
        end
        if (fl) q.delete();
        if (acc_enq) q.push_back('{idx: ei, pred: ep});
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d enq %b/%0d/%b res %b/%b flush %b -> count %0d w_v %b idx %0d cor %b uf %b mis %0d",
                 cyc, ev, ei, ep, rv, rt, fl, count, w_v, idx_w, correct, underflow, mis16);
        chk_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        @(negedge clk);
        rst = 1'b0;

        // Single predict-taken, resolved not-taken
        cycle(1, 4'd5, 1, 0, 0, 0);
        cycle(0, 4'd0, 0, 1, 0, 0);
        cycle(0, 4'd0, 0, 0, 0, 0);

        // Fill, refused 9th with concurrent resolve, then drain with wrap
        for (int i = 0; i < 8; i++) cycle(1, IW'(i), i[0], 0, 0, 0);
        cycle(1, 4'd8, 0, 1, 1, 0);
        cycle(1, 4'd8, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 4'd0, 0, 1, 0, 0);
        cycle(0, 4'd0, 0, 0, 0, 0);

        // Resolve on empty with concurrent enqueue
        cycle(1, 4'd3, 1, 1, 1, 0);
        cycle(0, 4'd0, 0, 0, 0, 0);
        cycle(0, 4'd0, 0, 1, 1, 0);

        // Flush beats resolve and enqueue
        for (int i = 0; i < 4; i++) cycle(1, IW'(i + 9), 1, 0, 0, 0);
        cycle(1, 4'd15, 0, 1, 0, 1);
        cycle(0, 4'd0, 0, 0, 0, 0);

        // Five mispredicts: 2-bit counter must saturate
        for (int i = 0; i < 5; i++) cycle(1, IW'(i), 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 4'd0, 0, 1, 0, 0);

        // Asynchronous reset mid-cycle with 3 entries and a resolve pending
        for (int i = 0; i < 3; i++) cycle(1, IW'(i + 6), 1, 0, 0, 0);
        @(negedge clk);
        enq_v = 1'b0; res_v = 1'b1; res_taken = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rst = 1'b0;
        res_v = 1'b0;
        cycle(0, 4'd0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) < 60), IW'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 55), 1'($urandom),
                  ($urandom_range(0, 99) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
